// File: rtl/aes_pkg.sv
// Shared definitions for the AES round stages: GF(2^8) helpers, the round-stage FSM states
// and the key-schedule row stride.
package aes_pkg;

  localparam int unsigned KEY_ROW_STRIDE = 120;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StCap,
    StWrA,
    StWrB,
    StDone
  } round_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Forward MixColumns on one 4-byte column; index r of the packed arrays is the state row.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [3:0][7:0] col_i,
  output logic [3:0][7:0] col_o
);

  always_comb begin
    col_o[0] = xtime(col_i[0]) ^ gf_mul3(col_i[1]) ^ col_i[2] ^ col_i[3];
    col_o[1] = col_i[0] ^ xtime(col_i[1]) ^ gf_mul3(col_i[2]) ^ col_i[3];
    col_o[2] = col_i[0] ^ col_i[1] ^ xtime(col_i[2]) ^ gf_mul3(col_i[3]);
    col_o[3] = gf_mul3(col_i[0]) ^ col_i[1] ^ col_i[2] ^ xtime(col_i[3]);
  end

endmodule

// File: rtl/mix_columns_add_round_key.sv
// AES encrypt round stage: MixColumns then AddRoundKey, applied column by column in place in
// the state RAM, with the ap_start/ap_done/ap_idle/ap_ready block handshake.
module mix_columns_add_round_key #(
  parameter int unsigned STATE_AW       = 5,
  parameter int unsigned KEY_AW         = 9,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned KEY_ROW_STRIDE = aes_pkg::KEY_ROW_STRIDE
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  output logic [STATE_AW-1:0] statemt_address0,
  output logic                statemt_ce0,
  output logic                statemt_we0,
  output logic [DATA_W-1:0]   statemt_d0,
  input  logic [DATA_W-1:0]   statemt_q0,
  output logic [STATE_AW-1:0] statemt_address1,
  output logic                statemt_ce1,
  output logic                statemt_we1,
  output logic [DATA_W-1:0]   statemt_d1,
  input  logic [DATA_W-1:0]   statemt_q1,
  input  logic [3:0]          n,
  output logic [KEY_AW-1:0]   word_address0,
  output logic                word_ce0,
  input  logic [DATA_W-1:0]   word_q0,
  output logic [KEY_AW-1:0]   word_address1,
  output logic                word_ce1,
  input  logic [DATA_W-1:0]   word_q1
);
  import aes_pkg::*;

  round_state_e    state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      n_q, n_d;
  logic [3:0][7:0] st_q, key_q;
  logic [3:0][7:0] mixed;
  logic [1:0]      row0, row1;
  logic            rd_phase, wr_phase;
  logic [7:0]      wr_byte0, wr_byte1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    n_d     = n_q;
    case (state_q)
      StIdle: begin
        if (ap_start) begin
          state_d = StRdA;
          col_d   = 2'd0;
          n_d     = n;
        end
      end
      StRdA: state_d = StRdB;
      StRdB: state_d = StCap;
      StCap: state_d = StWrA;
      StWrA: state_d = StWrB;
      StWrB: begin
        if (col_q == 2'd3) begin
          state_d = StDone;
        end else begin
          col_d   = col_q + 2'd1;
          state_d = StRdA;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read data lags the address by one cycle, so rows 0/1 land in RdB and rows 2/3 in Cap.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      col_q   <= 2'd0;
      n_q     <= 4'd0;
      st_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      n_q     <= n_d;
      if (state_q == StRdB) begin
        st_q[0]  <= statemt_q0[7:0];
        st_q[1]  <= statemt_q1[7:0];
        key_q[0] <= word_q0[7:0];
        key_q[1] <= word_q1[7:0];
      end
      if (state_q == StCap) begin
        st_q[2]  <= statemt_q0[7:0];
        st_q[3]  <= statemt_q1[7:0];
        key_q[2] <= word_q0[7:0];
        key_q[3] <= word_q1[7:0];
      end
    end
  end

  mix_column_unit u_mix (
    .col_i (st_q),
    .col_o (mixed)
  );

  // Port 0 serves the even row of the current pair, port 1 the odd row.
  assign row0     = {(state_q == StRdB) || (state_q == StWrB), 1'b0};
  assign row1     = {row0[1], 1'b1};
  assign rd_phase = (state_q == StRdA) || (state_q == StRdB);
  assign wr_phase = (state_q == StWrA) || (state_q == StWrB);
  assign wr_byte0 = mixed[row0] ^ key_q[row0];
  assign wr_byte1 = mixed[row1] ^ key_q[row1];

  assign statemt_address0 = STATE_AW'({col_q, row0});
  assign statemt_address1 = STATE_AW'({col_q, row1});
  assign statemt_ce0      = rd_phase | wr_phase;
  assign statemt_ce1      = rd_phase | wr_phase;
  assign statemt_we0      = wr_phase;
  assign statemt_we1      = wr_phase;
  assign statemt_d0       = DATA_W'(wr_byte0);
  assign statemt_d1       = DATA_W'(wr_byte1);

  assign word_address0 = KEY_AW'(32'(row0) * KEY_ROW_STRIDE + 32'(n_q) * 32'd4 + 32'(col_q));
  assign word_address1 = KEY_AW'(32'(row1) * KEY_ROW_STRIDE + 32'(n_q) * 32'd4 + 32'(col_q));
  assign word_ce0      = rd_phase;
  assign word_ce1      = rd_phase;

  assign ap_done  = (state_q == StDone);
  assign ap_ready = (state_q == StDone);
  assign ap_idle  = (state_q == StIdle);

  logic unused_q_hi;
  assign unused_q_hi = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8],
                         word_q0[DATA_W-1:8], word_q1[DATA_W-1:8]};

endmodule

// File: tb/tb_mix_columns_add_round_key.sv
// Bench for mix_columns_add_round_key: RAM models, FIPS-197 column table, a GF(2^8) reference
// model for random runs, and hand-written handshake and reset-abort sequences.
module tb_mix_columns_add_round_key;

  logic        clk = 1'b0;
  logic        ap_rst_n, ap_start, ap_done, ap_idle, ap_ready;
  logic [4:0]  statemt_address0, statemt_address1;
  logic        statemt_ce0, statemt_ce1, statemt_we0, statemt_we1;
  logic [31:0] statemt_d0, statemt_d1, statemt_q0, statemt_q1;
  logic [3:0]  n;
  logic [8:0]  word_address0, word_address1;
  logic        word_ce0, word_ce1;
  logic [31:0] word_q0, word_q1;

  logic [31:0] smem [0:31];
  logic [31:0] wmem [0:511];
  logic [7:0]  ref_st [0:15];
  int          checks = 0;
  int          failures = 0;
  int          viol = 0;
  int          done_pos[$];
  logic [63:0] idle_bits;

  typedef struct packed {
    logic [31:0] col_in;
    logic [31:0] col_exp;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  mix_columns_add_round_key dut (
    .ap_clk           (clk),
    .ap_rst_n         (ap_rst_n),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .statemt_address0 (statemt_address0),
    .statemt_ce0      (statemt_ce0),
    .statemt_we0      (statemt_we0),
    .statemt_d0       (statemt_d0),
    .statemt_q0       (statemt_q0),
    .statemt_address1 (statemt_address1),
    .statemt_ce1      (statemt_ce1),
    .statemt_we1      (statemt_we1),
    .statemt_d1       (statemt_d1),
    .statemt_q1       (statemt_q1),
    .n                (n),
    .word_address0    (word_address0),
    .word_ce0         (word_ce0),
    .word_q0          (word_q0),
    .word_address1    (word_address1),
    .word_ce1         (word_ce1),
    .word_q1          (word_q1)
  );

  always @(posedge clk) begin
    if (statemt_ce0) begin
      if (statemt_we0) smem[statemt_address0] <= statemt_d0;
      else             statemt_q0 <= smem[statemt_address0];
    end
    if (statemt_ce1) begin
      if (statemt_we1) smem[statemt_address1] <= statemt_d1;
      else             statemt_q1 <= smem[statemt_address1];
    end
    if (word_ce0) word_q0 <= wmem[word_address0];
    if (word_ce1) word_q1 <= wmem[word_address1];
  end

  // Protocol rules that must hold on every cycle out of reset.
  always @(negedge clk) begin
    if (ap_rst_n) begin
      if ((statemt_we0 && !statemt_ce0) || (statemt_we1 && !statemt_ce1)) viol++;
      if ((word_ce0 || word_ce1) && (statemt_we0 || statemt_we1)) viol++;
      if ((ap_idle || ap_done) && (statemt_ce0 || statemt_ce1 || word_ce0 || word_ce1)) viol++;
      if (statemt_we0 && statemt_d0[31:8] != 24'h0) viol++;
      if (statemt_we1 && statemt_d1[31:8] != 24'h0) viol++;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input int r, input int k);
    case ((k - r) & 3)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int r);
    return w[31-8*r -: 8];
  endfunction

  task automatic snapshot();
    for (int i = 0; i < 16; i++) ref_st[i] = smem[i][7:0];
  endtask

  task automatic model_round(input int nn);
    logic [7:0] tmp [0:15];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] m = 8'h00;
        for (int k = 0; k < 4; k++) m = m ^ gmul(coef(r, k), ref_st[k + 4*c]);
        tmp[r + 4*c] = m ^ wmem[r*120 + 4*nn + c][7:0];
      end
    end
    for (int i = 0; i < 16; i++) ref_st[i] = tmp[i];
  endtask

  task automatic compare_mem(input string nm);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_st%0d", nm, i), 64'(smem[i]), {32'h0, 24'h0, ref_st[i]});
  endtask

  task automatic fill_rand(input bit garbage);
    for (int i = 0; i < 32; i++) smem[i] = {garbage ? 24'($urandom) : 24'h0, 8'($urandom)};
    for (int a = 0; a < 512; a++) wmem[a] = {garbage ? 24'($urandom) : 24'h0, 8'($urandom)};
  endtask

  // Starts one operation from IDLE and records ap_done/ap_idle per cycle after the accept edge.
  task automatic start_run(input logic [3:0] nn, input bit hold, input int ncyc);
    done_pos.delete();
    idle_bits = '0;
    @(negedge clk);
    ap_start = 1'b1;
    n = nn;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin
        ap_start = 1'b0;
        n = ~nn;
      end
      idle_bits[c] = ap_idle;
      if (ap_done) done_pos.push_back(c);
      if (ap_ready !== ap_done) viol++;
    end
    ap_start = 1'b0;
  endtask

  task automatic run_checked(input string nm, input logic [3:0] nn);
    start_run(nn, 1'b0, 23);
    check({nm, "_done_cycle"}, (done_pos.size() == 1) ? 64'(done_pos[0]) : 64'(1000 + done_pos.size()),
          64'd21);
    check({nm, "_idle_profile"}, idle_bits, 64'h0000_0000_00C0_0000);
  endtask

  initial begin
    int dn;
    logic [31:0] colv;
    vecs[0] = '{32'hdb135345, 32'h8e4da1bc};
    vecs[1] = '{32'hf20a225c, 32'h9fdc589d};
    vecs[2] = '{32'hc6c6c6c6, 32'hc6c6c6c6};
    vecs[3] = '{32'hd4d4d4d5, 32'hd5d5d7d6};
    vecs[4] = '{32'h2d26314c, 32'h4d7ebdf8};

    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    n = 4'd0;
    fill_rand(1'b0);
    repeat (3) @(negedge clk);
    check("reset_idle", {ap_idle, ap_done, ap_ready}, 3'b100);
    check("reset_ce_we", {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1, word_ce0, word_ce1},
          6'b0);
    ap_rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", ap_idle, 1'b1);

    // FIPS-197 columns, zero key; odd vectors carry garbage in the upper bits.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++)
        smem[i] = {(v % 2) ? 24'hFFFFFF : 24'h0, byte_of(vecs[v].col_in, i % 4)};
      for (int a = 0; a < 512; a++) wmem[a] = {(v % 2) ? 24'($urandom) : 24'h0, 8'h00};
      run_checked($sformatf("fips%0d", v), 4'd0);
      for (int c = 0; c < 4; c++) begin
        colv = {smem[4*c][7:0], smem[4*c+1][7:0], smem[4*c+2][7:0], smem[4*c+3][7:0]};
        check($sformatf("fips%0d_col%0d", v, c), 64'(colv), 64'(vecs[v].col_exp));
      end
      check($sformatf("fips%0d_upper_zero", v),
            64'(smem[0][31:8] | smem[5][31:8] | smem[10][31:8] | smem[15][31:8]), 64'h0);
    end

    // Zero state, key word = address: each result byte identifies the key address read.
    for (int i = 0; i < 16; i++) smem[i] = 32'h0;
    for (int a = 0; a < 512; a++) wmem[a] = {24'($urandom), 8'(a)};
    run_checked("n10", 4'd10);
    for (int j = 0; j < 4; j++)
      for (int r = 0; r < 4; r++)
        check($sformatf("n10_addr_r%0d_c%0d", r, j), 64'(smem[r + 4*j]),
              64'((r*120 + 40 + j) & 8'hff));

    // Random state/key with garbage upper bits, including rounds past 10.
    for (int t = 0; t < 4; t++) begin
      logic [3:0] nn = (t == 3) ? 4'd15 : 4'($urandom);
      fill_rand(1'b1);
      snapshot();
      model_round(nn);
      run_checked($sformatf("rand%0d", t), nn);
      compare_mem($sformatf("rand%0d", t));
    end

    // ap_start held high: second run accepted only after an IDLE cycle.
    start_run(4'd5, 1'b1, 44);
    check("hold_done_count", 64'(done_pos.size()), 64'd2);
    if (done_pos.size() == 2) begin
      check("hold_done_first", 64'(done_pos[0]), 64'd21);
      check("hold_done_second", 64'(done_pos[1]), 64'd43);
    end
    check("hold_idle_gap", idle_bits[23:21], 3'b010);

    // Reset during column 2 WrA, then a clean restart.
    fill_rand(1'b0);
    dn = 0;
    @(negedge clk);
    ap_start = 1'b1;
    n = 4'd3;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      ap_start = 1'b0;
      if (ap_done) dn++;
    end
    check("abort_in_write", {statemt_we0, statemt_we1, word_ce0, statemt_address0},
          {3'b110, 5'd8});
    ap_rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_idle", {ap_idle, ap_done, ap_ready}, 3'b100);
    check("abort_ce_we", {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1, word_ce0, word_ce1},
          6'b0);
    ap_rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (ap_done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    snapshot();
    model_round(4'd3);
    run_checked("restart", 4'd3);
    compare_mem("restart");

    // Back-to-back rounds 1 and 2 starting from the FIPS-197 round-1 ShiftRows state.
    fill_rand(1'b0);
    begin
      logic [127:0] s_row = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
      for (int i = 0; i < 16; i++) smem[i] = {24'h0, s_row[127 - 8*i -: 8]};
    end
    snapshot();
    model_round(4'd1);
    run_checked("b2b_n1", 4'd1);
    compare_mem("b2b_n1");
    model_round(4'd2);
    run_checked("b2b_n2", 4'd2);
    compare_mem("b2b_n2");

    check("protocol_violations", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
